modulo_condicionador_entradas: RTL and testbench

MODULO_CONDICIONADOR_ENTRADAS -- requirements
Module: modulo_condicionador_entradas

---
 rtl/modulo_condicionador_entradas_pkg.sv | 16 +
 rtl/modulo_condicionador_entradas_debounce.sv | 77 +++++++
 rtl/modulo_condicionador_entradas.sv | 77 +++++++
 tb/tb_modulo_condicionador_entradas.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/modulo_condicionador_entradas_pkg.sv
// Shared definitions for the input conditioner: debounce FSM encoding and
// default timing parameters.
package modulo_condicionador_entradas_pkg;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_DEB_PRESS   = 2'd1,
        ST_HELD        = 2'd2,
        ST_DEB_RELEASE = 2'd3
    } deb_state_t;

    // 10 ms of stable level at 50 MHz
    localparam int DEB_CYCLES_DEFAULT  = 500000;
    localparam int SYNC_STAGES_DEFAULT = 2;

endpackage

// File: rtl/modulo_condicionador_entradas_debounce.sv
// One push-button channel: synchronizer, press/release debounce FSM and a
// single registered pulse per accepted press (no auto-repeat).
module modulo_debounce_botao
    import modulo_condicionador_entradas_pkg::*;
#(
    parameter int DEB_CYCLES  = DEB_CYCLES_DEFAULT,
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       btn_raw,
    output logic       fire,
    output logic       pulse,
    output deb_state_t state
);

    localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   level;
    deb_state_t             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    // Synchronizer resets to 1 so a released (active-low) button is seen.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            sync_q  <= '1;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pulse   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], btn_raw};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse   <= fire;
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign state = state_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        fire    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!level) state_d = ST_DEB_PRESS;
            end
            ST_DEB_PRESS: begin
                if (level) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_HELD;
                    fire    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_HELD: begin
                if (level) state_d = ST_DEB_RELEASE;
            end
            ST_DEB_RELEASE: begin
                if (!level) begin
                    state_d = ST_HELD;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: rtl/modulo_condicionador_entradas.sv
// Board input conditioner: two debounced buttons with clear-priority
// arbitration, a tracking mode bus and a coordinate snapshot taken on "fire".
module modulo_condicionador_entradas
    import modulo_condicionador_entradas_pkg::*;
#(
    parameter int DEB_CYCLES  = DEB_CYCLES_DEFAULT,
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       btn_clk_raw,
    input  logic       btn_clr_raw,
    input  logic [1:0] hh1_raw,
    input  logic [5:0] hh2_raw,
    output logic       button_clk,
    output logic       button_clr,
    output logic [1:0] hh1,
    output logic [5:0] hh2
);

    logic       fire_clk, fire_clr;
    logic       pulse_clk, pulse_clr;
    deb_state_t state_clk, state_clr;
    logic       block_clk, load_clk, clk_ok_q;
    logic [1:0] hh1_sync [SYNC_STAGES];
    logic [5:0] hh2_sync [SYNC_STAGES];
    logic       unused_state_clk;

    modulo_debounce_botao #(.DEB_CYCLES(DEB_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_deb_clk (
        .clk     (clk),
        .clr     (clr),
        .btn_raw (btn_clk_raw),
        .fire    (fire_clk),
        .pulse   (pulse_clk),
        .state   (state_clk)
    );

    modulo_debounce_botao #(.DEB_CYCLES(DEB_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_deb_clr (
        .clk     (clk),
        .clr     (clr),
        .btn_raw (btn_clr_raw),
        .fire    (fire_clr),
        .pulse   (pulse_clr),
        .state   (state_clr)
    );

    assign unused_state_clk = ^state_clk;

    // Clear wins: a fire press is dropped while clear fires or is still held.
    assign block_clk = fire_clr || (state_clr == ST_HELD) || (state_clr == ST_DEB_RELEASE);
    assign load_clk  = fire_clk && !block_clk;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                hh1_sync[i] <= '0;
                hh2_sync[i] <= '0;
            end
            clk_ok_q <= 1'b0;
            hh2      <= '0;
        end else begin
            hh1_sync[0] <= hh1_raw;
            hh2_sync[0] <= hh2_raw;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                hh1_sync[i] <= hh1_sync[i-1];
                hh2_sync[i] <= hh2_sync[i-1];
            end
            clk_ok_q <= !block_clk;
            if (load_clk) hh2 <= hh2_sync[SYNC_STAGES-1];
        end
    end

    assign hh1        = hh1_sync[SYNC_STAGES-1];
    assign button_clk = pulse_clk && clk_ok_q;
    assign button_clr = pulse_clr;

endmodule

// File: tb/tb_modulo_condicionador_entradas.sv
// Directed bench for the input conditioner with short debounce (4 cycles).
module tb_modulo_condicionador_entradas;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       btn_clk_raw = 1'b1;
    logic       btn_clr_raw = 1'b1;
    logic [1:0] hh1_raw = 2'b00;
    logic [5:0] hh2_raw = 6'b000000;
    logic       button_clk, button_clr;
    logic [1:0] hh1;
    logic [5:0] hh2;

    int         tests = 0;
    int         fails = 0;
    int         cyc, clk_cnt, clr_cnt, clk_first, clr_first;
    logic [5:0] hh2_prev, hh2_at_first, hh2_before_first;

    modulo_condicionador_entradas #(.DEB_CYCLES(4), .SYNC_STAGES(2)) dut (
        .clk         (clk),
        .clr         (clr),
        .btn_clk_raw (btn_clk_raw),
        .btn_clr_raw (btn_clr_raw),
        .hh1_raw     (hh1_raw),
        .hh2_raw     (hh2_raw),
        .button_clk  (button_clk),
        .button_clr  (button_clr),
        .hh1         (hh1),
        .hh2         (hh2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_counts();
        cyc          = 0;
        clk_cnt      = 0;
        clr_cnt      = 0;
        clk_first    = 0;
        clr_first    = 0;
        hh2_prev     = hh2;
        hh2_at_first = '0;
        hh2_before_first = '0;
    endtask

    // Cycle k is observed 1 time unit after the k-th rising edge since inputs changed.
    task automatic run(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
            if (button_clk === 1'b1) begin
                clk_cnt++;
                if (clk_first == 0) begin
                    clk_first        = cyc;
                    hh2_at_first     = hh2;
                    hh2_before_first = hh2_prev;
                end
            end
            if (button_clr === 1'b1) begin
                clr_cnt++;
                if (clr_first == 0) clr_first = cyc;
            end
            hh2_prev = hh2;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_counts();
        run(3);
        check("rst_button_clk", button_clk, 1'b0);
        check("rst_button_clr", button_clr, 1'b0);
        check("rst_hh1", hh1, 2'b00);
        check("rst_hh2", hh2, 6'b000000);
        hh1_raw = 2'b11;
        hh2_raw = 6'b111111;
        run(3);
        check("rst_hold_hh1", hh1, 2'b00);
        check("rst_hold_hh2", hh2, 6'b000000);

        clr = 1'b1;
        clear_counts();
        run(5);
        check("post_rst_no_clk", clk_cnt, 0);
        check("post_rst_no_clr", clr_cnt, 0);
        check("post_rst_hh1", hh1, 2'b11);
        check("post_rst_hh2", hh2, 6'b000000);

        hh1_raw = 2'b10;
        run(1);
        check("hh1_lat1", hh1, 2'b11);
        run(1);
        check("hh1_lat2", hh1, 2'b10);

        // Clean press with coordinate capture
        hh2_raw = 6'b011_010;
        btn_clk_raw = 1'b0;
        clear_counts();
        run(7);
        check("press_first_cycle", clk_first, 7);
        check("press_hh2_before", hh2_before_first, 6'b000000);
        check("press_hh2_at", hh2_at_first, 6'b011_010);
        hh2_raw = 6'b111_111;
        run(13);
        btn_clk_raw = 1'b1;
        run(12);
        check("press_pulse_count", clk_cnt, 1);
        check("press_hh2_kept", hh2, 6'b011_010);

        // Bouncing input never settles long enough
        hh2_raw = 6'b101_101;
        clear_counts();
        for (int i = 0; i < 8; i++) begin
            btn_clk_raw = 1'b0;
            run(2);
            btn_clk_raw = 1'b1;
            run(2);
        end
        run(12);
        check("bounce_no_pulse", clk_cnt, 0);
        check("bounce_hh2", hh2, 6'b011_010);

        // Simultaneous presses: clear wins
        hh2_raw = 6'b000_111;
        btn_clk_raw = 1'b0;
        btn_clr_raw = 1'b0;
        clear_counts();
        run(10);
        btn_clk_raw = 1'b1;
        btn_clr_raw = 1'b1;
        run(12);
        check("both_clr_count", clr_cnt, 1);
        check("both_clr_first", clr_first, 7);
        check("both_clk_count", clk_cnt, 0);
        check("both_hh2", hh2, 6'b011_010);

        // Long hold with a one-cycle release glitch
        hh2_raw = 6'b110_001;
        btn_clk_raw = 1'b0;
        clear_counts();
        run(100);
        btn_clk_raw = 1'b1;
        run(1);
        btn_clk_raw = 1'b0;
        run(20);
        btn_clk_raw = 1'b1;
        run(12);
        check("glitch_first", clk_first, 7);
        check("glitch_count", clk_cnt, 1);
        check("glitch_hh2", hh2, 6'b110_001);

        // Reset asserted mid-debounce with the button still held
        hh2_raw = 6'b001_100;
        btn_clk_raw = 1'b0;
        clear_counts();
        run(4);
        clr = 1'b0;
        run(2);
        check("midrst_clk_count", clk_cnt, 0);
        check("midrst_button_clk", button_clk, 1'b0);
        check("midrst_hh1", hh1, 2'b00);
        check("midrst_hh2", hh2, 6'b000000);
        clr = 1'b1;
        clear_counts();
        run(12);
        check("midrst_first", clk_first, 7);
        check("midrst_count", clk_cnt, 1);
        check("midrst_hh2_load", hh2, 6'b001_100);
        check("midrst_hh1_back", hh1, 2'b10);
        btn_clk_raw = 1'b1;
        run(12);

        // Fire press discarded while clear is held
        hh2_raw = 6'b111_000;
        btn_clr_raw = 1'b0;
        clear_counts();
        run(12);
        btn_clk_raw = 1'b0;
        run(15);
        check("clrheld_clr_count", clr_cnt, 1);
        check("clrheld_clk_count", clk_cnt, 0);
        check("clrheld_hh2", hh2, 6'b001_100);
        btn_clk_raw = 1'b1;
        btn_clr_raw = 1'b1;
        run(15);

        hh1_raw = 2'b01;
        run(2);
        check("hh1_final", hh1, 2'b01);
        check("hh2_final", hh2, 6'b001_100);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
